// File: rtl/dcm_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dcm_lock_ctrl
// Brief    : DCM reset/lock sequencer; pulses DCM RST, qualifies LOCKED and
//            CLKFX-stopped, releases the system reset once lock is stable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dcm_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000,
    parameter logic [15:0] STABLE_CYCLES = 16'd256,
    parameter logic [3:0]  MAX_RETRY     = 4'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    input  logic       dcm_fx_stopped,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [15:0] c_RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] c_LOCK_LAST   = LOCK_TIMEOUT - 16'd1;
    localparam logic [15:0] c_STABLE_LAST = STABLE_CYCLES - 16'd1;

    typedef enum logic [2:0] {
        S_RESET_DCM = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAILED    = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_rel;
    logic [1:0]  r_lock_sync;
    logic [1:0]  r_stop_sync;
    logic        r_dcm_rst;
    logic        r_sys_rst;
    logic        r_ready;
    logic        r_fail;
    logic [3:0]  r_retry;
    logic [7:0]  r_loss;

    state_t      w_next;
    logic        w_retry_path;
    logic [3:0]  w_retry_nxt;
    logic [7:0]  w_loss_nxt;
    logic        w_locked_s;
    logic        w_stop_s;

    assign w_locked_s = r_lock_sync[1];
    assign w_stop_s   = r_stop_sync[1];

    always_comb begin
        w_next       = r_state;
        w_retry_path = 1'b0;
        w_retry_nxt  = r_retry;
        w_loss_nxt   = r_loss;
        case (r_state)
            S_RESET_DCM: begin
                if (!r_rel && (r_timer == c_RST_LAST)) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes precedence over a coincident timeout.
                if (w_locked_s) begin
                    w_next = S_STABILIZE;
                end else if (r_timer == c_LOCK_LAST) begin
                    w_retry_path = 1'b1;
                end
            end
            S_STABILIZE: begin
                if (!w_locked_s || w_stop_s) begin
                    w_retry_path = 1'b1;
                end else if (r_timer == c_STABLE_LAST) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_locked_s || w_stop_s) begin
                    w_next = S_RESET_DCM;
                    if (r_loss != 8'hFF) begin
                        w_loss_nxt = r_loss + 8'd1;
                    end
                end
            end
            S_FAILED: begin
                w_next = S_FAILED;
            end
            default: begin
                w_next = S_RESET_DCM;
            end
        endcase

        if (w_retry_path) begin
            if (r_retry == MAX_RETRY) begin
                w_next = S_FAILED;
            end else begin
                w_next      = S_RESET_DCM;
                w_retry_nxt = r_retry + 4'd1;
            end
        end

        if ((w_next == S_RUN) && (r_state != S_RUN)) begin
            w_retry_nxt = 4'd0;
        end
    end

    // The first edge after reset release is not counted, so dcm_rst stays
    // high for RST_CYCLES full cycles once rst drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET_DCM;
            r_timer     <= 16'd0;
            r_rel       <= 1'b1;
            r_lock_sync <= 2'b00;
            r_stop_sync <= 2'b00;
            r_dcm_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_retry     <= 4'd0;
            r_loss      <= 8'd0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], dcm_locked};
            r_stop_sync <= {r_stop_sync[0], dcm_fx_stopped};
            r_rel       <= 1'b0;
            r_state     <= w_next;
            if ((w_next != r_state) || r_rel) begin
                r_timer <= 16'd0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_dcm_rst   <= (w_next == S_RESET_DCM) || (w_next == S_FAILED);
            r_sys_rst   <= (w_next != S_RUN);
            r_ready     <= (w_next == S_RUN);
            r_fail      <= (w_next == S_FAILED);
        end
    end

    assign dcm_rst   = r_dcm_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_dcm_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_dcm_lock_ctrl
// Brief    : Directed self-checking bench for dcm_lock_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dcm_lock_ctrl;

    logic       clk;
    logic       rst;
    logic       dcm_locked;
    logic       dcm_fx_stopped;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dcm_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (16'd32),
        .STABLE_CYCLES (16'd8),
        .MAX_RETRY     (4'd2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .dcm_locked     (dcm_locked),
        .dcm_fx_stopped (dcm_fx_stopped),
        .dcm_rst        (dcm_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fail           (fail),
        .retry_cnt      (retry_cnt),
        .loss_cnt       (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".dcm_rst"}, 32'(dcm_rst), 32'd1);
        check({tag, ".sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, ".ready"},   32'(ready),   32'd0);
        check({tag, ".fail"},    32'(fail),    32'd0);
        check({tag, ".retry"},   32'(retry_cnt), 32'd0);
        check({tag, ".loss"},    32'(loss_cnt),  32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        dcm_locked     = 1'b0;
        dcm_fx_stopped = 1'b0;

        // Power-on reset and normal lock
        step(3);
        check_reset_vals("por");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("por_pulse_hi", 32'(dcm_rst), 32'd1);
        end
        step(1);
        check("por_pulse_fall", 32'(dcm_rst), 32'd0);
        step(9);
        dcm_locked = 1'b1;
        step(10);
        check("lock_sys_rst_hold", 32'(sys_rst), 32'd1);
        check("lock_ready_low", 32'(ready), 32'd0);
        step(1);
        check("lock_sys_rst_rel", 32'(sys_rst), 32'd0);
        check("lock_ready", 32'(ready), 32'd1);
        check("lock_retry", 32'(retry_cnt), 32'd0);
        check("lock_dcm_rst", 32'(dcm_rst), 32'd0);

        // Loss of lock in RUN
        dcm_locked = 1'b0;
        step(2);
        check("loss_ready_still", 32'(ready), 32'd1);
        step(1);
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_dcm_rst", 32'(dcm_rst), 32'd1);
        check("loss_cnt1", 32'(loss_cnt), 32'd1);
        check("loss_retry", 32'(retry_cnt), 32'd0);
        dcm_locked = 1'b1;
        step(3);
        check("loss_pulse_hi", 32'(dcm_rst), 32'd1);
        step(1);
        check("loss_pulse_fall", 32'(dcm_rst), 32'd0);
        step(8);
        check("loss_relock_hold", 32'(sys_rst), 32'd1);
        step(1);
        check("loss_relock_ready", 32'(ready), 32'd1);

        // Remaining 299 losses; counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            dcm_locked = 1'b0;
            step(3);
            dcm_locked = 1'b1;
            step(13);
            check("loss_loop_ready", 32'(ready), 32'd1);
        end
        check("loss_sat", 32'(loss_cnt), 32'd255);

        // CLKFX stopped while locked
        dcm_fx_stopped = 1'b1;
        step(2);
        check("fx_ready_still", 32'(ready), 32'd1);
        step(1);
        check("fx_sys_rst", 32'(sys_rst), 32'd1);
        check("fx_dcm_rst", 32'(dcm_rst), 32'd1);
        check("fx_ready", 32'(ready), 32'd0);
        check("fx_loss_sat", 32'(loss_cnt), 32'd255);
        dcm_fx_stopped = 1'b0;
        step(13);
        check("fx_relock_ready", 32'(ready), 32'd1);
        check("fx_retry", 32'(retry_cnt), 32'd0);

        // Glitch during STABILIZE
        dcm_locked = 1'b0;
        step(3);
        dcm_locked = 1'b1;
        step(5);
        check("gl_stab_sys_rst", 32'(sys_rst), 32'd1);
        step(4);
        dcm_locked = 1'b0;
        step(2);
        check("gl_pre_retry", 32'(dcm_rst), 32'd0);
        step(1);
        check("gl_retry_dcm_rst", 32'(dcm_rst), 32'd1);
        check("gl_retry_cnt", 32'(retry_cnt), 32'd1);
        check("gl_sys_rst", 32'(sys_rst), 32'd1);
        step(3);
        check("gl_pulse_hi", 32'(dcm_rst), 32'd1);
        step(1);
        check("gl_pulse_fall", 32'(dcm_rst), 32'd0);
        dcm_locked = 1'b1;
        step(10);
        check("gl_relock_hold", 32'(sys_rst), 32'd1);
        check("gl_retry_hold", 32'(retry_cnt), 32'd1);
        step(1);
        check("gl_run_ready", 32'(ready), 32'd1);
        check("gl_run_retry_clr", 32'(retry_cnt), 32'd0);

        // Reset in WAIT_LOCK after one retry
        rst        = 1'b1;
        dcm_locked = 1'b0;
        step(1);
        check_reset_vals("rst_run");
        rst = 1'b0;
        step(5);
        check("rm_w1_entry", 32'(dcm_rst), 32'd0);
        step(31);
        check("rm_timeout_m1", 32'(dcm_rst), 32'd0);
        step(1);
        check("rm_timeout", 32'(dcm_rst), 32'd1);
        check("rm_retry1", 32'(retry_cnt), 32'd1);
        step(4);
        check("rm_w2_entry", 32'(dcm_rst), 32'd0);
        step(5);
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_mid");
        rst = 1'b0;

        // Never locks: three pulses then FAILED
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("nl_p1_hi", 32'(dcm_rst), 32'd1);
        end
        step(1);
        check("nl_p1_fall", 32'(dcm_rst), 32'd0);
        step(32);
        check("nl_p2_rise", 32'(dcm_rst), 32'd1);
        check("nl_retry1", 32'(retry_cnt), 32'd1);
        step(3);
        check("nl_p2_hi", 32'(dcm_rst), 32'd1);
        step(1);
        check("nl_p2_fall", 32'(dcm_rst), 32'd0);
        step(32);
        check("nl_p3_rise", 32'(dcm_rst), 32'd1);
        check("nl_retry2", 32'(retry_cnt), 32'd2);
        check("nl_no_fail_yet", 32'(fail), 32'd0);
        step(4);
        check("nl_p3_fall", 32'(dcm_rst), 32'd0);
        step(31);
        check("nl_pre_fail", 32'(fail), 32'd0);
        step(1);
        check("nl_fail", 32'(fail), 32'd1);
        check("nl_fail_dcm_rst", 32'(dcm_rst), 32'd1);
        check("nl_fail_sys_rst", 32'(sys_rst), 32'd1);
        check("nl_fail_ready", 32'(ready), 32'd0);
        check("nl_fail_retry", 32'(retry_cnt), 32'd2);
        dcm_locked = 1'b1;
        step(100);
        check("nl_fail_hold", 32'(fail), 32'd1);
        check("nl_fail_hold_dcm", 32'(dcm_rst), 32'd1);
        check("nl_fail_hold_sys", 32'(sys_rst), 32'd1);

        // Exit FAILED by reset; lock coinciding with timeout goes to STABILIZE
        rst        = 1'b1;
        dcm_locked = 1'b0;
        step(1);
        check_reset_vals("rst_fail");
        rst = 1'b0;
        step(5);
        check("co_w_entry", 32'(dcm_rst), 32'd0);
        step(29);
        dcm_locked = 1'b1;
        step(3);
        check("co_lock_wins", 32'(dcm_rst), 32'd0);
        check("co_retry", 32'(retry_cnt), 32'd0);
        step(7);
        check("co_stab_hold", 32'(sys_rst), 32'd1);
        step(1);
        check("co_run_ready", 32'(ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
